// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues in-order imem requests, buffers returned words, feeds decode.
// Latency: IMEM_RVALID in cycle N -> INSTR_VALID in cycle N+1 (0 cycles with FETCH_BYPASS_EN and an empty buffer).
// Backpressure: INSTR_READY low fills the buffer; requests stop once outstanding + buffered reaches BUF_DEPTH.
//
// Ports: CLK/RESET (sync, active-high); IMEM_REQ/IMEM_ADDR/IMEM_GNT request side;
//        IMEM_RVALID/IMEM_RDATA in-order response side; REDIRECT/REDIRECT_PC branch target;
//        INSTR_VALID/INSTR_READY/INSTR/INSTR_PC/INSTRUCTION_FORMAT decode side.
// Optional feature macro: FETCH_BYPASS_EN (same-cycle response bypass when the buffer is empty).
module fetch_unit #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter int          BUF_DEPTH = 2
) (
   input  logic        CLK,
   input  logic        RESET,
   output logic        IMEM_REQ,
   output logic [31:0] IMEM_ADDR,
   input  logic        IMEM_GNT,
   input  logic        IMEM_RVALID,
   input  logic [31:0] IMEM_RDATA,
   input  logic        REDIRECT,
   input  logic [31:0] REDIRECT_PC,
   output logic        INSTR_VALID,
   input  logic        INSTR_READY,
   output logic [31:0] INSTR,
   output logic [31:0] INSTR_PC,
   output logic [6:0]  INSTRUCTION_FORMAT
);

   localparam int CW = $clog2(BUF_DEPTH + 1);
   localparam int PW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;

   typedef enum logic [1:0] {ST_BOOT, ST_RUN, ST_FLUSH} state_t;

   state_t        state_q, state_d;
   logic [31:0]   pc_q, pc_d;
   logic [31:0]   resp_pc_q, resp_pc_d;
   logic [CW-1:0] outstanding_q, outstanding_d;
   logic [CW-1:0] drop_q, drop_d;
   logic [CW-1:0] count_q, count_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [31:0]   instr_mem_q [BUF_DEPTH];
   logic [31:0]   instr_mem_d [BUF_DEPTH];
   logic [31:0]   pc_mem_q    [BUF_DEPTH];
   logic [31:0]   pc_mem_d    [BUF_DEPTH];

   logic          in_run;
   logic          fifo_empty;
   logic          fifo_full;
   logic [CW:0]   credit_used;
   logic          grant;
   logic          rsp_dec;
   logic          bypass_vld;
   logic          bypass_take;
   logic          push;
   logic          pop_fifo;
   logic [CW-1:0] rem;
   logic [31:0]   redirect_tgt;
   logic          unused_redirect_lsb;

   assign unused_redirect_lsb = ^REDIRECT_PC[1:0];
   assign redirect_tgt        = {REDIRECT_PC[31:2], 2'b00};

   assign in_run      = (state_q == ST_RUN);
   assign fifo_empty  = (count_q == '0);
   assign fifo_full   = (count_q == CW'(BUF_DEPTH));
   // Buffered entries hold credit until popped, so the buffer can never overflow.
   assign credit_used = {1'b0, outstanding_q} + {1'b0, count_q};
   assign IMEM_REQ    = in_run && !REDIRECT && (credit_used < (CW+1)'(BUF_DEPTH));
   assign IMEM_ADDR   = pc_q;
   assign grant       = IMEM_REQ && IMEM_GNT;
   // Guard against a stray response so the counter cannot underflow.
   assign rsp_dec     = IMEM_RVALID && (outstanding_q != '0);

`ifdef FETCH_BYPASS_EN
   assign bypass_vld  = in_run && fifo_empty && IMEM_RVALID && !REDIRECT;
`else
   assign bypass_vld  = 1'b0;
`endif
   // A bypassed word taken by decode is consumed and never enters the buffer.
   assign bypass_take = bypass_vld && INSTR_READY;
   assign push        = in_run && !REDIRECT && IMEM_RVALID && !bypass_take;
   assign pop_fifo    = in_run && !REDIRECT && !fifo_empty && INSTR_READY;

   always_comb begin
      INSTR_VALID = 1'b0;
      INSTR       = 32'h0;
      INSTR_PC    = 32'h0;
      if (bypass_vld) begin
         INSTR_VALID = 1'b1;
         INSTR       = IMEM_RDATA;
         INSTR_PC    = resp_pc_q;
      end else if (in_run && !fifo_empty) begin
         INSTR_VALID = 1'b1;
         INSTR       = instr_mem_q[rd_ptr_q];
         INSTR_PC    = pc_mem_q[rd_ptr_q];
      end
   end
   assign INSTRUCTION_FORMAT = INSTR[6:0];

   always_comb begin
      state_d       = state_q;
      pc_d          = pc_q;
      resp_pc_d     = resp_pc_q;
      outstanding_d = outstanding_q;
      drop_d        = drop_q;
      count_d       = count_q;
      rd_ptr_d      = rd_ptr_q;
      wr_ptr_d      = wr_ptr_q;
      instr_mem_d   = instr_mem_q;
      pc_mem_d      = pc_mem_q;
      rem           = '0;
      case (state_q)
         ST_BOOT: state_d = ST_RUN;
         ST_RUN: begin
            if (REDIRECT) begin
               // Buffer and same-cycle response are discarded; remaining in-flight words are dropped in FLUSH.
               pc_d          = redirect_tgt;
               resp_pc_d     = redirect_tgt;
               count_d       = '0;
               rd_ptr_d      = '0;
               wr_ptr_d      = '0;
               outstanding_d = '0;
               rem           = outstanding_q - CW'(rsp_dec);
               if (rem != '0) begin
                  drop_d  = rem;
                  state_d = ST_FLUSH;
               end
            end else begin
               if (grant) pc_d = pc_q + 32'd4;
               if (IMEM_RVALID) resp_pc_d = resp_pc_q + 32'd4;
               outstanding_d = outstanding_q + CW'(grant) - CW'(rsp_dec);
               if (push) begin
                  instr_mem_d[wr_ptr_q] = IMEM_RDATA;
                  pc_mem_d[wr_ptr_q]    = resp_pc_q;
                  wr_ptr_d = (wr_ptr_q == PW'(BUF_DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
               end
               if (pop_fifo) begin
                  rd_ptr_d = (rd_ptr_q == PW'(BUF_DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
               end
               count_d = count_q + CW'(push) - CW'(pop_fifo);
            end
         end
         ST_FLUSH: begin
            if (REDIRECT) begin
               pc_d      = redirect_tgt;
               resp_pc_d = redirect_tgt;
            end
            if (IMEM_RVALID && (drop_q != '0)) begin
               drop_d = drop_q - 1'b1;
               if (drop_q == CW'(1)) state_d = ST_RUN;
            end else if (drop_q == '0) begin
               state_d = ST_RUN;
            end
         end
         default: state_d = ST_BOOT;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q       <= ST_BOOT;
         pc_q          <= RESET_PC;
         resp_pc_q     <= RESET_PC;
         outstanding_q <= '0;
         drop_q        <= '0;
         count_q       <= '0;
         rd_ptr_q      <= '0;
         wr_ptr_q      <= '0;
         instr_mem_q   <= '{default: '0};
         pc_mem_q      <= '{default: '0};
      end else begin
         state_q       <= state_d;
         pc_q          <= pc_d;
         resp_pc_q     <= resp_pc_d;
         outstanding_q <= outstanding_d;
         drop_q        <= drop_d;
         count_q       <= count_d;
         rd_ptr_q      <= rd_ptr_d;
         wr_ptr_q      <= wr_ptr_d;
         instr_mem_q   <= instr_mem_d;
         pc_mem_q      <= pc_mem_d;
      end
   end

   // Overflow is impossible while the credit rule holds; trap any violation.
   assert property (@(posedge CLK) disable iff (RESET) !(push && fifo_full && !pop_fifo));

endmodule
